// File: rtl/bcd_to_bin.sv
// Sequential 6-digit packed-BCD to 20-bit binary converter (reverse double-dabble).
// One word every 41 cycles: 20 shift steps interleaved with 19 per-digit minus-3 corrections.
module bcd_to_bin (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] bcd_in,
  input  logic        bcd_valid,
  output logic        bcd_ready,
  output logic [19:0] data_out,
  output logic        data_valid,
  output logic        bcd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    ADJUST = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam logic [4:0] NUM_SHIFTS = 5'd20;

  state_t      state_q;
  logic [43:0] work_q;
  logic [4:0]  cnt_q;
  logic        err_q;
  logic [19:0] data_out_q;
  logic        data_valid_q;
  logic        bcd_err_q;

  logic [43:0] work_adj_d;
  logic [4:0]  cnt_d;
  logic        in_err_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    work_adj_d = work_q;
    in_err_d   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (work_q[20 + 4*i +: 4] >= 4'd8) begin
        work_adj_d[20 + 4*i +: 4] = work_q[20 + 4*i +: 4] - 4'd3;
      end
      if (bcd_in[4*i +: 4] > 4'd9) begin
        in_err_d = 1'b1;
      end
    end
    cnt_d = cnt_q + 5'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      bcd_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bcd_valid) begin
            work_q  <= {bcd_in, 20'd0};
            cnt_q   <= '0;
            err_q   <= in_err_d;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          work_q  <= work_q >> 1;
          cnt_q   <= cnt_d;
          state_q <= (cnt_d == NUM_SHIFTS) ? OUT : ADJUST;
        end
        ADJUST: begin
          work_q  <= work_adj_d;
          state_q <= SHIFT;
        end
        OUT: begin
          // A word with a non-decimal digit still runs the full sequence; its result is forced to zero.
          data_out_q   <= err_q ? 20'd0 : work_q[19:0];
          bcd_err_q    <= err_q;
          data_valid_q <= 1'b1;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bcd_ready  = (state_q == IDLE);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus randomized BCD words
// compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [23:0] bcd_in;
  logic        bcd_valid;
  logic        bcd_ready;
  logic [19:0] data_out;
  logic        data_valid;
  logic        bcd_err;

  int pass_cnt;
  int total_cnt;

  bcd_to_bin dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bcd_err    (bcd_err)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  // Reference: read the six digits as a decimal number; any digit above 9 flags an error and zeroes the result.
  function automatic void model(input logic [23:0] w, output logic [19:0] v, output logic e);
    int acc;
    int d;
    acc = 0;
    e   = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      d = int'(w[4*i +: 4]);
      if (d > 9) e = 1'b1;
      acc = acc * 10 + d;
    end
    v = e ? 20'd0 : acc[19:0];
  endfunction

  // Offers one word, waits for its strobe, and reports what was observed (lat = -1 on timeout).
  task automatic convert(input logic [23:0] w, output logic [19:0] dout, output logic err,
                         output int lat, output int rlow, output bit changed);
    int n;
    logic [19:0] held;
    @(negedge sys_clk);
    bcd_in    = w;
    bcd_valid = 1'b1;
    n = 0;
    while (!bcd_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    bcd_in    = 24'($urandom);
    held      = data_out;
    lat       = 0;
    rlow      = 0;
    changed   = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (!bcd_ready) rlow++;
      if (data_valid) break;
      if (data_out !== held) changed = 1'b1;
      if (lat >= 100) begin
        lat = -1;
        break;
      end
      @(posedge sys_clk);
      lat++;
    end
    dout = data_out;
    err  = bcd_err;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    bcd_valid = 1'b0;
    bcd_in    = '0;
    repeat (3) @(negedge sys_clk);
    total_cnt++;
    if ({bcd_ready, data_out, data_valid, bcd_err} !== {1'b1, 20'd0, 1'b0, 1'b0})
      $display("FAIL reset_during: ready=%b out=%h valid=%b err=%b, required 1/00000/0/0",
               bcd_ready, data_out, data_valid, bcd_err);
    else pass_cnt++;
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    total_cnt++;
    if ({bcd_ready, data_out, data_valid, bcd_err} !== {1'b1, 20'd0, 1'b0, 1'b0})
      $display("FAIL reset_after: ready=%b out=%h valid=%b err=%b, required 1/00000/0/0",
               bcd_ready, data_out, data_valid, bcd_err);
    else pass_cnt++;
  endtask

  task automatic test_max();
    logic [19:0] d;
    logic e;
    int lat, rlow;
    bit ch;
    convert(24'h999999, d, e, lat, rlow, ch);
    total_cnt++;
    if (d !== 20'hF423F || e !== 1'b0)
      $display("FAIL max_value: out=%h err=%b, required F423F/0", d, e);
    else pass_cnt++;
    total_cnt++;
    if (lat !== 40) $display("FAIL max_latency: got %0d cycles, required 40", lat);
    else pass_cnt++;
    total_cnt++;
    if (rlow !== 40) $display("FAIL max_ready_low: got %0d cycles, required 40", rlow);
    else pass_cnt++;
    total_cnt++;
    if (bcd_ready !== 1'b1) $display("FAIL max_ready_with_strobe: got %b, required 1", bcd_ready);
    else pass_cnt++;
    @(negedge sys_clk);
    total_cnt++;
    if (data_valid !== 1'b0 || bcd_err !== 1'b0 || data_out !== 20'hF423F)
      $display("FAIL max_strobe_one_cycle: valid=%b err=%b out=%h, required 0/0/F423F",
               data_valid, bcd_err, data_out);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [23:0] words [4] = '{24'h000000, 24'h000009, 24'h123456, 24'h100000};
    logic [19:0] expv  [4] = '{20'h00000, 20'h00009, 20'h1E240, 20'h186A0};
    logic [19:0] d;
    logic e;
    int lat, rlow;
    bit ch;
    for (int i = 0; i < 4; i++) begin
      convert(words[i], d, e, lat, rlow, ch);
      total_cnt++;
      if (d !== expv[i] || e !== 1'b0 || lat !== 40)
        $display("FAIL seq_%0d: in=%h out=%h err=%b lat=%0d, required %h/0/40",
                 i, words[i], d, e, lat, expv[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_invalid();
    logic [19:0] d;
    logic e;
    int lat, rlow;
    bit ch;
    convert(24'h00A000, d, e, lat, rlow, ch);
    total_cnt++;
    if (d !== 20'd0 || e !== 1'b1 || lat !== 40)
      $display("FAIL invalid_digit: out=%h err=%b lat=%0d, required 00000/1/40", d, e, lat);
    else pass_cnt++;
    convert(24'h000123, d, e, lat, rlow, ch);
    total_cnt++;
    if (d !== 20'h0007B || e !== 1'b0 || lat !== 40)
      $display("FAIL after_invalid: out=%h err=%b lat=%0d, required 0007B/0/40", d, e, lat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [23:0] words [4] = '{24'h000777, 24'h999999, 24'h050505, 24'h314159};
    logic [19:0] res [$];
    logic        res_err [$];
    int acc_cyc [$];
    int idx, cyc, extra;
    logic [19:0] ev;
    logic ee;
    idx = 0;
    cyc = 0;
    while (res.size() < 4 && cyc < 400) begin
      @(negedge sys_clk);
      cyc++;
      if (data_valid) begin
        res.push_back(data_out);
        res_err.push_back(bcd_err);
      end
      if (bcd_ready) begin
        if (idx < 4) begin
          bcd_in    = words[idx];
          bcd_valid = 1'b1;
          acc_cyc.push_back(cyc);
          idx++;
        end else begin
          bcd_valid = 1'b0;
        end
      end else begin
        bcd_in = 24'($urandom);
      end
    end
    bcd_valid = 1'b0;
    total_cnt++;
    if (res.size() !== 4) $display("FAIL b2b_count: got %0d results, required 4", res.size());
    else pass_cnt++;
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total_cnt++;
      if (acc_cyc[i] - acc_cyc[i-1] !== 41)
        $display("FAIL b2b_interval_%0d: got %0d cycles, required 41", i, acc_cyc[i] - acc_cyc[i-1]);
      else pass_cnt++;
    end
    for (int i = 0; i < res.size(); i++) begin
      model(words[i], ev, ee);
      total_cnt++;
      if (res[i] !== ev || res_err[i] !== ee)
        $display("FAIL b2b_result_%0d: out=%h err=%b, required %h/%b", i, res[i], res_err[i], ev, ee);
      else pass_cnt++;
    end
    extra = 0;
    repeat (45) begin
      @(negedge sys_clk);
      if (data_valid) extra++;
    end
    total_cnt++;
    if (extra !== 0) $display("FAIL b2b_extra_strobes: got %0d, required 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [19:0] d;
    logic e;
    int lat, rlow, n, strobes;
    bit ch;
    @(negedge sys_clk);
    bcd_in    = 24'h654321;
    bcd_valid = 1'b1;
    n = 0;
    while (!bcd_ready && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk);
    #1;
    bcd_valid = 1'b0;
    repeat (15) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bcd_ready, data_out, data_valid, bcd_err} !== {1'b1, 20'd0, 1'b0, 1'b0})
      $display("FAIL reset_mid_outputs: ready=%b out=%h valid=%b err=%b, required 1/00000/0/0",
               bcd_ready, data_out, data_valid, bcd_err);
    else pass_cnt++;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    strobes = 0;
    repeat (50) begin
      @(negedge sys_clk);
      if (data_valid) strobes++;
    end
    total_cnt++;
    if (strobes !== 0) $display("FAIL reset_mid_no_strobe: got %0d strobes, required 0", strobes);
    else pass_cnt++;
    convert(24'h000042, d, e, lat, rlow, ch);
    total_cnt++;
    if (d !== 20'h0002A || e !== 1'b0 || lat !== 40)
      $display("FAIL after_reset_mid: out=%h err=%b lat=%0d, required 0002A/0/40", d, e, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [23:0] w;
    logic [19:0] d, ev;
    logic e, ee;
    int lat, rlow;
    bit ch;
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < 6; i++) w[4*i +: 4] = 4'($urandom_range(0, 9));
      model(w, ev, ee);
      convert(w, d, e, lat, rlow, ch);
      total_cnt++;
      if (d !== ev || e !== ee || lat !== 40)
        $display("FAIL rand_%0d: in=%h out=%h err=%b lat=%0d, required %h/%b/40", t, w, d, e, lat, ev, ee);
      else pass_cnt++;
      total_cnt++;
      if (ch !== 1'b0) $display("FAIL rand_hold_%0d: data_out changed between strobes, required stable", t);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    sys_rst_n = 1'b0;
    bcd_valid = 1'b0;
    bcd_in    = '0;
    test_reset();
    test_max();
    test_sequence();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
